// File: rtl/timer_pkg.sv
// Shared types for the multi-channel countdown timer.
package timer_pkg;

    typedef enum logic {
        ONESHOT  = 1'b0,
        PERIODIC = 1'b1
    } timer_mode_e;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: count/reload/mode state plus timeup, expire and sticky irq.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         en,
    input  logic         ld,
    input  logic [N-1:0] ld_value,
    input  logic         ld_mode,
    input  logic         irq_clr,
    output logic [N-1:0] count,
    output logic         timeup,
    output logic         expire,
    output logic         irq
);

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] reload_q, reload_d;
    timer_mode_e  mode_q, mode_d;
    logic         timeup_q, timeup_d;
    logic         expire_q, expire_d;
    logic         irq_q, irq_d;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        timeup_d = timeup_q;
        expire_d = 1'b0;
        irq_d    = irq_q & ~irq_clr;

        if (ld) begin
            count_d  = ld_value;
            reload_d = ld_value;
            mode_d   = timer_mode_e'(ld_mode);
            timeup_d = (ld_value == '0);
        end else if (tick && en && (count_q > N'(1))) begin
            count_d  = count_q - N'(1);
            timeup_d = 1'b0;
        end else if (tick && en && (count_q == N'(1))) begin
            // Expiry sets irq after the clear term so a coincident clear loses.
            expire_d = 1'b1;
            irq_d    = 1'b1;
            if (mode_q == PERIODIC) begin
                count_d  = reload_q;
                timeup_d = (reload_q == '0);
            end else begin
                count_d  = '0;
                timeup_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= ONESHOT;
            timeup_q <= 1'b0;
            expire_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            timeup_q <= timeup_d;
            expire_q <= expire_d;
            irq_q    <= irq_d;
        end
    end

    assign count  = count_q;
    assign timeup = timeup_q;
    assign expire = expire_q;
    assign irq    = irq_q;

endmodule

// File: rtl/multi_countdown_timer.sv
// CH countdown channels sharing one programmable prescaler, with load decode and count readback.
module multi_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned CH         = 4,
    parameter int unsigned PRESCALE_W = 8,
    localparam int unsigned SEL_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] presc_div,
    input  logic [CH-1:0]         enable,
    input  logic                  load,
    input  logic [SEL_W-1:0]      load_ch,
    input  logic [N-1:0]          load_value,
    input  logic                  load_mode,
    input  logic [CH-1:0]         irq_clr,
    input  logic [SEL_W-1:0]      rd_ch,
    output logic [N-1:0]          rd_count,
    output logic [CH-1:0]         timeup,
    output logic [CH-1:0]         expire,
    output logic [CH-1:0]         irq
);

    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  tick;
    logic [CH-1:0]         ld_sel;
    logic [CH-1:0][N-1:0]  count_all;

    // A shrunk presc_div below p lets p run on and wrap naturally.
    assign tick = (p_q == presc_div);

    always_comb begin
        p_d = tick ? '0 : p_q + PRESCALE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) p_q <= '0;
        else       p_q <= p_d;
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign ld_sel[i] = load && (load_ch == SEL_W'(i));

        timer_channel #(.N(N)) u_channel (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .en       (enable[i]),
            .ld       (ld_sel[i]),
            .ld_value (load_value),
            .ld_mode  (load_mode),
            .irq_clr  (irq_clr[i]),
            .count    (count_all[i]),
            .timeup   (timeup[i]),
            .expire   (expire[i]),
            .irq      (irq[i])
        );
    end

    always_comb begin
        rd_count = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (rd_ch == SEL_W'(k)) rd_count = count_all[k];
        end
    end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Directed table-driven bench for multi_countdown_timer plus hand-written corner sequences.
module tb_multi_countdown_timer;

    logic       clk;
    logic       reset;
    logic [7:0] presc_div;
    logic [3:0] enable;
    logic       load;
    logic [1:0] load_ch;
    logic [7:0] load_value;
    logic       load_mode;
    logic [3:0] irq_clr;
    logic [1:0] rd_ch;
    logic [7:0] rd_count;
    logic [3:0] timeup, expire, irq;

    logic [7:0] presc_div3;
    logic [2:0] enable3;
    logic       load3;
    logic [1:0] load_ch3;
    logic [7:0] load_value3;
    logic       load_mode3;
    logic [2:0] irq_clr3;
    logic [1:0] rd_ch3;
    logic [7:0] rd_count3;
    logic [2:0] timeup3, expire3, irq3;

    int passed = 0;
    int total  = 0;

    multi_countdown_timer #(.N(8), .CH(4), .PRESCALE_W(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .presc_div  (presc_div),
        .enable     (enable),
        .load       (load),
        .load_ch    (load_ch),
        .load_value (load_value),
        .load_mode  (load_mode),
        .irq_clr    (irq_clr),
        .rd_ch      (rd_ch),
        .rd_count   (rd_count),
        .timeup     (timeup),
        .expire     (expire),
        .irq        (irq)
    );

    // Three-channel instance so that an out-of-range load_ch/rd_ch is representable.
    multi_countdown_timer #(.N(8), .CH(3), .PRESCALE_W(8)) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .presc_div  (presc_div3),
        .enable     (enable3),
        .load       (load3),
        .load_ch    (load_ch3),
        .load_value (load_value3),
        .load_mode  (load_mode3),
        .irq_clr    (irq_clr3),
        .rd_ch      (rd_ch3),
        .rd_count   (rd_count3),
        .timeup     (timeup3),
        .expire     (expire3),
        .irq        (irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pd;
        logic [3:0] en;
        logic       ld;
        logic [1:0] lch;
        logic [7:0] lval;
        logic       lmode;
        logic [3:0] clr;
        logic [1:0] rch;
        logic [7:0] cnt;
        logic [3:0] tu;
        logic [3:0] ex;
        logic [3:0] irq;
    } vec_t;

    localparam int NV = 23;
    vec_t v[NV];

    function automatic vec_t mk(logic [7:0] pd, logic [3:0] en, logic ld, logic [1:0] lch,
                                logic [7:0] lval, logic lmode, logic [3:0] clr, logic [1:0] rch,
                                logic [7:0] cnt, logic [3:0] tu, logic [3:0] ex, logic [3:0] iq);
        vec_t r;
        r.pd = pd; r.en = en; r.ld = ld; r.lch = lch; r.lval = lval; r.lmode = lmode;
        r.clr = clr; r.rch = rch; r.cnt = cnt; r.tu = tu; r.ex = ex; r.irq = iq;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else             passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // presc_div=0 one-shot countdown on ch0
        v[0]  = mk(8'd0, 4'b0001, 1, 2'd0, 8'd3, 0, 4'b0000, 2'd0, 8'd3, 4'b0000, 4'b0000, 4'b0000);
        v[1]  = mk(8'd0, 4'b0001, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd0, 8'd2, 4'b0000, 4'b0000, 4'b0000);
        v[2]  = mk(8'd0, 4'b0001, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd0, 8'd1, 4'b0000, 4'b0000, 4'b0000);
        v[3]  = mk(8'd0, 4'b0001, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd0, 8'd0, 4'b0001, 4'b0001, 4'b0001);
        v[4]  = mk(8'd0, 4'b0001, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd0, 8'd0, 4'b0001, 4'b0000, 4'b0001);
        v[5]  = mk(8'd0, 4'b0001, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd0, 8'd0, 4'b0001, 4'b0000, 4'b0001);
        // load zero on ch2: timeup, no expire/irq, ticks ignored
        v[6]  = mk(8'd0, 4'b0101, 1, 2'd2, 8'd0, 0, 4'b0000, 2'd2, 8'd0, 4'b0101, 4'b0000, 4'b0001);
        v[7]  = mk(8'd0, 4'b0101, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd2, 8'd0, 4'b0101, 4'b0000, 4'b0001);
        // irq clear racing an expiry on ch0
        v[8]  = mk(8'd0, 4'b0101, 1, 2'd0, 8'd1, 0, 4'b0001, 2'd0, 8'd1, 4'b0100, 4'b0000, 4'b0000);
        v[9]  = mk(8'd0, 4'b0101, 0, 2'd0, 8'd0, 0, 4'b0001, 2'd0, 8'd0, 4'b0101, 4'b0001, 4'b0001);
        v[10] = mk(8'd0, 4'b0101, 0, 2'd0, 8'd0, 0, 4'b0001, 2'd0, 8'd0, 4'b0101, 4'b0000, 4'b0000);
        // load ch0 while ch1 decrements on the same tick
        v[11] = mk(8'd0, 4'b0101, 1, 2'd1, 8'd4, 0, 4'b0000, 2'd1, 8'd4, 4'b0101, 4'b0000, 4'b0000);
        v[12] = mk(8'd0, 4'b0111, 1, 2'd0, 8'd5, 0, 4'b0000, 2'd1, 8'd3, 4'b0100, 4'b0000, 4'b0000);
        v[13] = mk(8'd0, 4'b0000, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd0, 8'd5, 4'b0100, 4'b0000, 4'b0000);
        // presc_div=3 periodic reload on ch1
        v[14] = mk(8'd3, 4'b0010, 1, 2'd1, 8'd2, 1, 4'b0000, 2'd1, 8'd2, 4'b0100, 4'b0000, 4'b0000);
        v[15] = mk(8'd3, 4'b0010, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd1, 8'd2, 4'b0100, 4'b0000, 4'b0000);
        v[16] = mk(8'd3, 4'b0010, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd1, 8'd2, 4'b0100, 4'b0000, 4'b0000);
        v[17] = mk(8'd3, 4'b0010, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd1, 8'd1, 4'b0100, 4'b0000, 4'b0000);
        v[18] = mk(8'd3, 4'b0010, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd1, 8'd1, 4'b0100, 4'b0000, 4'b0000);
        v[19] = mk(8'd3, 4'b0010, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd1, 8'd1, 4'b0100, 4'b0000, 4'b0000);
        v[20] = mk(8'd3, 4'b0010, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd1, 8'd1, 4'b0100, 4'b0000, 4'b0000);
        v[21] = mk(8'd3, 4'b0010, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd1, 8'd2, 4'b0100, 4'b0010, 4'b0010);
        v[22] = mk(8'd3, 4'b0010, 0, 2'd0, 8'd0, 0, 4'b0000, 2'd1, 8'd2, 4'b0100, 4'b0000, 4'b0010);

        reset = 1'b1; presc_div = '0; enable = '0; load = 1'b0; load_ch = '0;
        load_value = '0; load_mode = 1'b0; irq_clr = '0; rd_ch = '0;
        presc_div3 = '0; enable3 = '0; load3 = 1'b0; load_ch3 = '0;
        load_value3 = '0; load_mode3 = 1'b0; irq_clr3 = '0; rd_ch3 = '0;

        step();
        step();
        chk("reset.cnt", 32'(rd_count), 0);
        chk("reset.tu",  32'(timeup),   0);
        chk("reset.ex",  32'(expire),   0);
        chk("reset.irq", 32'(irq),      0);
        chk("reset3.tu", 32'(timeup3),  0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            presc_div = v[i].pd; enable = v[i].en; load = v[i].ld; load_ch = v[i].lch;
            load_value = v[i].lval; load_mode = v[i].lmode; irq_clr = v[i].clr; rd_ch = v[i].rch;
            step();
            chk($sformatf("v%0d.cnt", i), 32'(rd_count), 32'(v[i].cnt));
            chk($sformatf("v%0d.tu",  i), 32'(timeup),   32'(v[i].tu));
            chk($sformatf("v%0d.ex",  i), 32'(expire),   32'(v[i].ex));
            chk($sformatf("v%0d.irq", i), 32'(irq),      32'(v[i].irq));
        end

        // Reset landing on the edge where ch3 would expire.
        presc_div = '0; enable = '0; load = 1'b0; irq_clr = '0;
        reset = 1'b1;
        step();
        reset = 1'b0; load = 1'b1; load_ch = 2'd3; load_value = 8'd1; load_mode = 1'b0; rd_ch = 2'd3;
        step();
        chk("rst6.loaded", 32'(rd_count), 1);
        load = 1'b0; enable = 4'b1000; reset = 1'b1;
        step();
        chk("rst6.cnt", 32'(rd_count), 0);
        chk("rst6.tu",  32'(timeup),   0);
        chk("rst6.ex",  32'(expire),   0);
        chk("rst6.irq", 32'(irq),      0);
        reset = 1'b0; enable = '0;
        step();
        chk("rst6.ex_after",  32'(expire), 0);
        chk("rst6.irq_after", 32'(irq),    0);

        // Out-of-range load/readback on the three-channel instance.
        load3 = 1'b1; load_ch3 = 2'd0; load_value3 = 8'd9; rd_ch3 = 2'd0;
        step();
        chk("ch3inst.ld0", 32'(rd_count3), 9);
        load_ch3 = 2'd3; load_value3 = 8'd7;
        step();
        load3 = 1'b0;
        chk("oor.ch0", 32'(rd_count3), 9);
        rd_ch3 = 2'd1; #1;
        chk("oor.ch1", 32'(rd_count3), 0);
        rd_ch3 = 2'd2; #1;
        chk("oor.ch2", 32'(rd_count3), 0);
        rd_ch3 = 2'd3; #1;
        chk("oor.rd",  32'(rd_count3), 0);
        chk("oor.tu",  32'(timeup3),   0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
